// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch responder.
package inst_fetch_resp_pkg;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_BUSY = 1'b1
  } if_state_e;

  localparam logic RSTENABLE  = 1'b1;
  localparam logic CHIPENABLE = 1'b1;

  // Width of a counter that must reach n-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/if_line_buf.sv
// One-entry fetch buffer: tag/data/valid with combinational hit compare.
module if_line_buf
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] lookup_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag_i;
    end
  end

  // Data is only observable through a valid hit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) data_q <= wr_data_i;
  end

  assign hit_o  = valid_q & (tag_q == lookup_i);
  assign data_o = data_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: serves pc from a one-entry buffer, misses go over a req/ack bus.
// Optional bus timeout abort is enabled by defining IF_TIMEOUT_EN.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  output logic [DATA_W-1:0] inst,
  output logic              stallreq,
  output logic              fetch_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (TMO_CYC < 1) begin : g_tmo_chk
    $error("TMO_CYC must be at least 1");
  end

  if_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fetch_err_q, fetch_err_d;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_tag_d;
  logic [DATA_W-1:0] buf_data_d;
  logic              hit;
  logic [DATA_W-1:0] buf_data;
  logic              miss;

`ifdef IF_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TMO_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  if_line_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (buf_we),
    .wr_tag_i (buf_tag_d),
    .wr_data_i(buf_data_d),
    .lookup_i (pc),
    .hit_o    (hit),
    .data_o   (buf_data)
  );

  assign miss     = (ce == CHIPENABLE) & ~hit;
  assign stallreq = miss;
  assign inst     = ((ce == CHIPENABLE) && hit) ? buf_data : '0;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fetch_err_d = 1'b0;
    buf_we      = 1'b0;
    buf_tag_d   = '0;
    buf_data_d  = '0;
`ifdef IF_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IF_IDLE: begin
        if (miss) begin
          if (pc[1:0] == 2'b00) begin
            state_d    = IF_BUSY;
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
`ifdef IF_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            // Misaligned pc: park a NOP under that tag so the pipeline can move on.
            buf_we      = 1'b1;
            buf_tag_d   = pc;
            fetch_err_d = 1'b1;
          end
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          buf_we     = 1'b1;
          buf_tag_d  = mem_addr_q;
          buf_data_d = mem_rdata;
          mem_req_d  = 1'b0;
          state_d    = IF_IDLE;
        end
`ifdef IF_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
          buf_we      = 1'b1;
          buf_tag_d   = mem_addr_q;
          fetch_err_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IF_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state_q     <= IF_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      fetch_err_q <= 1'b0;
`ifdef IF_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_err_q <= fetch_err_d;
`ifdef IF_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp with a scoreboard of expected fetched words.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst, ce, mem_ack;
  logic [31:0] pc, mem_rdata;
  logic [31:0] inst, mem_addr;
  logic        stallreq, fetch_err, mem_req;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  inst_fetch_resp #(
    .ADDR_W (32),
    .DATA_W (32),
    .TMO_CYC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .ce       (ce),
    .inst     (inst),
    .stallreq (stallreq),
    .fetch_err(fetch_err),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus responder: waits (bounded) for a request, queues the expected word, acks after lat cycles.
  task automatic serve(input logic [31:0] data, input int lat, output bit ok, output logic [31:0] addr);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      addr = mem_addr;
      exp_q.push_back(data);
      repeat (lat) tick();
      mem_ack   = 1'b1;
      mem_rdata = data;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; pc = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) begin
      tick();
      n_cmp++;
      if ({mem_req, inst, stallreq, fetch_err} !== 35'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got req=%b inst=%h stall=%b err=%b want all 0",
                 mem_req, inst, stallreq, fetch_err);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp;
    int req_cycles;
    ce = 1'b1; pc = 32'h0;
    #1;
    req_cycles = 0;
    n_cmp++;
    if (stallreq !== 1'b1) begin n_err++; $display("FAIL ff_stall_c1: got %b want 1", stallreq); end
    tick();
    n_cmp++;
    if (stallreq !== 1'b1) begin n_err++; $display("FAIL ff_stall_c2: got %b want 1", stallreq); end
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL ff_req: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr);
    end
    if (mem_req === 1'b1) req_cycles++;
    exp_q.push_back(32'h3C010001);
    mem_ack = 1'b1; mem_rdata = 32'h3C010001;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    exp = exp_q.pop_front();
    n_cmp++;
    if (stallreq !== 1'b0 || inst !== exp) begin
      n_err++; $display("FAIL ff_fill: got stall=%b inst=%h want stall=0 inst=%h", stallreq, inst, exp);
    end
    repeat (3) begin
      tick();
      if (mem_req === 1'b1) req_cycles++;
    end
    n_cmp++;
    if (req_cycles != 1) begin n_err++; $display("FAIL ff_req_pulses: got %0d want 1", req_cycles); end
  endtask

  task automatic test_hold_hit();
    bit ok;
    logic [31:0] addr, exp;
    pc = 32'h4;
    serve(32'h8C220004, 2, ok, addr);
    n_cmp++;
    if (!ok || addr !== 32'h4) begin
      n_err++; $display("FAIL hold_req: got ok=%b addr=%h want ok=1 addr=00000004", ok, addr);
    end
    if (ok) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (stallreq !== 1'b0 || inst !== exp) begin
        n_err++; $display("FAIL hold_fill: got stall=%b inst=%h want 0/%h", stallreq, inst, exp);
      end
      repeat (5) begin
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || stallreq !== 1'b0 || inst !== exp) begin
          n_err++; $display("FAIL hold_stable: got req=%b stall=%b inst=%h want 0/0/%h",
                            mem_req, stallreq, inst, exp);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    pc = 32'h6;
    #1;
    n_cmp++;
    if (stallreq !== 1'b1) begin n_err++; $display("FAIL mis_stall_pre: got %b want 1", stallreq); end
    tick();
    n_cmp++;
    if (fetch_err !== 1'b1 || mem_req !== 1'b0 || stallreq !== 1'b0 || inst !== 32'h0) begin
      n_err++; $display("FAIL mis_err: got err=%b req=%b stall=%b inst=%h want 1/0/0/00000000",
                        fetch_err, mem_req, stallreq, inst);
    end
    tick();
    n_cmp++;
    if (fetch_err !== 1'b0 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL mis_pulse_end: got err=%b req=%b want 0/0", fetch_err, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] addr, exp;
    for (int k = 0; k < 2; k++) begin
      pc = 32'h10 + 32'(4 * k);
      serve(32'hA0000000 + 32'(k), 0, ok, addr);
      n_cmp++;
      if (!ok || addr !== pc) begin
        n_err++; $display("FAIL b2b_req: got ok=%b addr=%h want ok=1 addr=%h", ok, addr, pc);
      end
      if (ok) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if (stallreq !== 1'b0 || inst !== exp) begin
          n_err++; $display("FAIL b2b_fill: got stall=%b inst=%h want 0/%h", stallreq, inst, exp);
        end
      end
    end
  endtask

  task automatic test_pc_change_busy();
    bit ok;
    logic [31:0] addr, exp;
    pc = 32'h20;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
      n_err++; $display("FAIL pcb_req0: got req=%b addr=%h want 1/00000020", mem_req, mem_addr);
    end
    pc = 32'h24;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    n_cmp++;
    if (stallreq !== 1'b1 || inst !== 32'h0) begin
      n_err++; $display("FAIL pcb_old_fill: got stall=%b inst=%h want 1/00000000", stallreq, inst);
    end
    serve(32'h22222222, 1, ok, addr);
    n_cmp++;
    if (!ok || addr !== 32'h24) begin
      n_err++; $display("FAIL pcb_req1: got ok=%b addr=%h want ok=1 addr=00000024", ok, addr);
    end
    if (ok) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (stallreq !== 1'b0 || inst !== exp) begin
        n_err++; $display("FAIL pcb_fill: got stall=%b inst=%h want 0/%h", stallreq, inst, exp);
      end
    end
  endtask

  task automatic test_ce_low();
    ce = 1'b0;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0 || inst !== 32'h0) begin
      n_err++; $display("FAIL ce_low_hit: got stall=%b inst=%h want 0/00000000", stallreq, inst);
    end
    pc = 32'h30;
    repeat (3) begin
      tick();
      n_cmp++;
      if (mem_req !== 1'b0 || stallreq !== 1'b0) begin
        n_err++; $display("FAIL ce_low_miss: got req=%b stall=%b want 0/0", mem_req, stallreq);
      end
    end
  endtask

  task automatic test_reset_busy();
    bit ok;
    logic [31:0] addr, exp;
    ce = 1'b1; pc = 32'h8;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
      n_err++; $display("FAIL rb_req: got req=%b addr=%h want 1/00000008", mem_req, mem_addr);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (mem_req !== 1'b0 || stallreq !== 1'b1) begin
      n_err++; $display("FAIL rb_drop: got req=%b stall=%b want 0/1", mem_req, stallreq);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (stallreq !== 1'b1 || inst !== 32'h0) begin
      n_err++; $display("FAIL rb_ack_ignored: got stall=%b inst=%h want 1/00000000", stallreq, inst);
    end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    n_cmp++;
    if (stallreq !== 1'b1 || inst !== 32'h0) begin
      n_err++; $display("FAIL rb_idle_ack: got stall=%b inst=%h want 1/00000000", stallreq, inst);
    end
    serve(32'h00851020, 1, ok, addr);
    n_cmp++;
    if (!ok || addr !== 32'h8) begin
      n_err++; $display("FAIL rb_refetch: got ok=%b addr=%h want ok=1 addr=00000008", ok, addr);
    end
    if (ok) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (stallreq !== 1'b0 || inst !== exp) begin
        n_err++; $display("FAIL rb_fill: got stall=%b inst=%h want 0/%h", stallreq, inst, exp);
      end
    end
  endtask

  task automatic test_timeout();
`ifndef IF_TIMEOUT_EN
    bit ok;
    logic [31:0] addr, exp;
`endif
    pc = 32'hC;
    tick();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin
      n_err++; $display("FAIL tmo_req: got req=%b addr=%h want 1/0000000c", mem_req, mem_addr);
    end
`ifdef IF_TIMEOUT_EN
    repeat (3) begin
      tick();
      n_cmp++;
      if (mem_req !== 1'b1 || stallreq !== 1'b1) begin
        n_err++; $display("FAIL tmo_wait: got req=%b stall=%b want 1/1", mem_req, stallreq);
      end
    end
    tick();
    n_cmp++;
    if (mem_req !== 1'b0 || fetch_err !== 1'b1 || inst !== 32'h0 || stallreq !== 1'b0) begin
      n_err++; $display("FAIL tmo_abort: got req=%b err=%b inst=%h stall=%b want 0/1/00000000/0",
                        mem_req, fetch_err, inst, stallreq);
    end
    tick();
    n_cmp++;
    if (fetch_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_end: got %b want 0", fetch_err); end
`else
    repeat (20) begin
      tick();
      n_cmp++;
      if (mem_req !== 1'b1 || stallreq !== 1'b1 || fetch_err !== 1'b0) begin
        n_err++; $display("FAIL tmo_wait_forever: got req=%b stall=%b err=%b want 1/1/0",
                          mem_req, stallreq, fetch_err);
      end
    end
    serve(32'h3C1F0000, 0, ok, addr);
    n_cmp++;
    if (!ok || addr !== 32'hC) begin
      n_err++; $display("FAIL tmo_late_ack: got ok=%b addr=%h want ok=1 addr=0000000c", ok, addr);
    end
    if (ok) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (stallreq !== 1'b0 || inst !== exp) begin
        n_err++; $display("FAIL tmo_late_fill: got stall=%b inst=%h want 0/%h", stallreq, inst, exp);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold_hit();
    test_misaligned();
    test_back_to_back();
    test_pc_change_busy();
    test_ce_low();
    test_reset_busy();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
